// File: rtl/seg_pkg.sv
// Glyph tables and lookup helpers shared by the seven-segment scan driver.
// Glyphs are active-low cathode patterns ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic {
    GLYPH_HEX    = 1'b0,
    GLYPH_LETTER = 1'b1
  } glyph_mode_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] HEX_0 = 7'b1000000;
  localparam logic [6:0] HEX_1 = 7'b1111001;
  localparam logic [6:0] HEX_2 = 7'b0100100;
  localparam logic [6:0] HEX_3 = 7'b0110000;
  localparam logic [6:0] HEX_4 = 7'b0011001;
  localparam logic [6:0] HEX_5 = 7'b0010010;
  localparam logic [6:0] HEX_6 = 7'b0000010;
  localparam logic [6:0] HEX_7 = 7'b1111000;
  localparam logic [6:0] HEX_8 = 7'b0000000;
  localparam logic [6:0] HEX_9 = 7'b0010000;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_B = 7'b0000011;
  localparam logic [6:0] HEX_C = 7'b1000110;
  localparam logic [6:0] HEX_D = 7'b0100001;
  localparam logic [6:0] HEX_E = 7'b0000110;
  localparam logic [6:0] HEX_F = 7'b0001110;

  localparam logic [6:0] LET_E = 7'b0000110;
  localparam logic [6:0] LET_N = 7'b0101011;
  localparam logic [6:0] LET_D = 7'b0100001;
  localparam logic [6:0] LET_P = 7'b0001100;
  localparam logic [6:0] LET_O = 7'b1000000;
  localparam logic [6:0] LET_I = 7'b1001111;
  localparam logic [6:0] LET_T = 7'b0000111;
  localparam logic [6:0] LET_Q = 7'b0011000;
  localparam logic [6:0] LET_U = 7'b1000001;
  localparam logic [6:0] LET_A = 7'b0001000;
  localparam logic [6:0] LET_R = 7'b0101111;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = HEX_0;
      4'h1:    g = HEX_1;
      4'h2:    g = HEX_2;
      4'h3:    g = HEX_3;
      4'h4:    g = HEX_4;
      4'h5:    g = HEX_5;
      4'h6:    g = HEX_6;
      4'h7:    g = HEX_7;
      4'h8:    g = HEX_8;
      4'h9:    g = HEX_9;
      4'hA:    g = HEX_A;
      4'hB:    g = HEX_B;
      4'hC:    g = HEX_C;
      4'hD:    g = HEX_D;
      4'hE:    g = HEX_E;
      4'hF:    g = HEX_F;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Codes past the last letter render dark.
  function automatic logic [6:0] letter_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = LET_E;
      4'h1:    g = LET_N;
      4'h2:    g = LET_D;
      4'h3:    g = LET_P;
      4'h4:    g = LET_O;
      4'h5:    g = LET_I;
      4'h6:    g = LET_T;
      4'h7:    g = LET_Q;
      4'h8:    g = LET_U;
      4'h9:    g = LET_A;
      4'hA:    g = LET_R;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational nibble-to-glyph lookup selecting the hex or letter set.
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       mode_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = SEG_BLANK;
    if (mode_i == GLYPH_LETTER) begin
      glyph_o = letter_glyph(nibble_i);
    end else begin
      glyph_o = hex_glyph(nibble_i);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with PWM brightness, blink, blanking
// and a shadow register that commits new content only at frame boundaries.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int DIV_W   = 10,
  parameter int BLINK_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic [DIGITS-1:0]     blink_i,
  input  logic                  mode_i,
  input  logic [3:0]            bright_i,
  input  logic                  load_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = '1;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLINK_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [DIGITS-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic                pend_mode_q, pend_mode_d, act_mode_q, act_mode_d;

  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_q, frame_d;

  logic                boundary_s;
  logic [3:0]          cur_nib_s;
  logic [3:0]          level_s;
  logic                lit_s;
  logic [6:0]          glyph_s;

  seg_glyph_rom u_glyph_rom (
    .nibble_i (cur_nib_s),
    .mode_i   (act_mode_q),
    .glyph_o  (glyph_s)
  );

  // Scan counters and shadow registers; a load coinciding with the boundary
  // reaches the active copy through pend_*_d in the same cycle.
  always_comb begin
    boundary_s = (div_q == DIV_LAST) && (idx_q == IDX_LAST);
    div_d      = div_q + DIV_W'(1);
    idx_d      = idx_q;
    if (div_q == DIV_LAST) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end

    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_blink_d = pend_blink_q;
    pend_mode_d  = pend_mode_q;
    if (load_i) begin
      pend_data_d  = data_i;
      pend_dp_d    = dp_i;
      pend_blank_d = blank_i;
      pend_blink_d = blink_i;
      pend_mode_d  = mode_i;
    end else begin
      pend_data_d  = pend_data_q;
    end

    frame_cnt_d = frame_cnt_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_blink_d = act_blink_q;
    act_mode_d  = act_mode_q;
    if (boundary_s) begin
      frame_cnt_d = frame_cnt_q + BLINK_W'(1);
      act_data_d  = pend_data_d;
      act_dp_d    = pend_dp_d;
      act_blank_d = pend_blank_d;
      act_blink_d = pend_blink_d;
      act_mode_d  = pend_mode_d;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Pin values for the digit currently being scanned.
  always_comb begin
    cur_nib_s = act_data_q[{idx_q, 2'b00} +: 4];
    level_s   = div_q[DIV_W-1 -: 4];
    lit_s     = !act_blank_q[idx_q]
             && !(act_blink_q[idx_q] && frame_cnt_q[BLINK_W-1])
             && (level_s <= bright_i);
    an_d      = '1;
    seg_d     = SEG_BLANK;
    dp_d      = 1'b1;
    if (lit_s) begin
      an_d  = ~(DIGITS'(1'b1) << idx_q);
      seg_d = glyph_s;
      dp_d  = ~act_dp_q[idx_q];
    end else begin
      an_d  = '1;
    end
    frame_d = boundary_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q        <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_blink_q <= '0;
      pend_mode_q  <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      act_blink_q  <= '0;
      act_mode_q   <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_blink_q <= pend_blink_d;
      pend_mode_q  <= pend_mode_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      act_blink_q  <= act_blink_d;
      act_mode_q   <= act_mode_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment scan driver, the next-generation display back end for lab boards. It drives DIGITS common-anode digits from a packed nibble bus and selects between the hex glyph set and the letter glyph set at run time. On top of plain scanning it adds per-digit decimal point, blanking and blinking, 16-level PWM brightness, and a tear-free shadow load that commits new data only at a frame boundary. It sits between the lab top level and the board anode/cathode pins.

## Interface
- DIGITS, 8, number of digits scanned (2..16)
- DIV_W, 10, dwell counter width; each digit is held 2^DIV_W cycles (DIV_W >= 4)
- BLINK_W, 6, frame counter width; blink phase is its MSB
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- data_i  in  4*DIGITS  nibble k drives digit k (digit 0 = bits [3:0])
- dp_i  in  DIGITS  decimal point request per digit, 1 = lit
- blank_i  in  DIGITS  1 = digit forced dark
- blink_i  in  DIGITS  1 = digit dark during blink phase
- mode_i  in  1  0 = hex glyphs, 1 = letter glyphs
- bright_i  in  4  brightness level 0..15
- load_i  in  1  single-cycle strobe; captures all data/dp/blank/blink/mode inputs into the pending register
- an_o  out  DIGITS  anode enables, active-low
- seg_o  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp_o  out  1  decimal-point cathode, active-low
- frame_o  out  1  one-cycle pulse at each frame boundary (commit point)

## Operation
- Dwell counter div_cnt (DIV_W bits) free-runs. When it wraps to 0, digit index idx advances; idx wraps from DIGITS-1 to 0.
- Frame boundary: the cycle where div_cnt == 2^DIV_W-1 and idx == DIGITS-1. In that cycle the active register loads from pending, frame_o pulses in the following cycle, and the frame counter increments (wraps mod 2^BLINK_W).
- Same-cycle load_i and boundary: the committed value is the inputs presented with load_i (bypass), so no frame is lost.
- load_i outside a boundary updates only pending. Displayed content never changes mid-frame.
- bright_i is sampled live, not shadowed.
- Digit lit when all of: blank bit 0; not (blink bit 1 and blink phase 1); div_cnt[DIV_W-1 -: 4] <= bright_i. 15 = 100% duty, 0 = 1/16 duty.
- When lit: an_o has only bit idx low, seg_o = glyph of the active nibble, dp_o = ~dp bit. When dark: an_o, seg_o and dp_o are all ones.
- Hex glyphs 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Letter glyphs 0..A: E 0000110, N 0101011, D 0100001, P 0001100, O 1000000, I 1001111, T 0000111, Q 0011000, U 1000001, A 0001000, R 0101111. Codes B..F are blank (1111111).

## Timing
- All outputs are registered: one cycle latency from counter/active-register state to pins.
- Reset (asynchronous): div_cnt, idx, frame counter, pending and active all 0; an_o, seg_o, dp_o all ones; frame_o 0.
- After reset release, the first cycle shows an_o = ~1 (digit 0) with the hex '0' glyph at any bright_i.
- Reset asserted mid-frame blanks the outputs immediately and discards pending. No commit occurs.
- Frame period = DIGITS * 2^DIV_W cycles. Blink period = 2^BLINK_W frames at 50% duty.

## Structure
- Package seg_pkg: glyph constants for both tables, SEG_BLANK, and functions hex_glyph and letter_glyph.
- Sub-module seg_glyph_rom: combinational nibble + mode -> 7-bit glyph.
- All counters, shadow registers and output registers live in seg_scan_driver.

## Test plan
Bench parameters: DIGITS=8, DIV_W=4, BLINK_W=3.
- Reset released, bright 15, no load -> an_o cycles FE, FD, .., 7F every 16 cycles; seg_o = 1000000; frame_o every 128 cycles.
- load_i with data 0x76543210, mode 0 mid-frame -> display stays 0 until the next frame_o, then digit 3 shows 0110000.
- mode 1, data 0xA9876543 -> digit 0 shows P 0001100, digit 7 R 0101111; nibble 0xB shows blank.
- bright_i=3 -> each digit's anode is low exactly 4 of 16 dwell cycles (div_cnt upper nibble 0..3).
- blink_i=0x01, blank_i=0x80, dp_i=0x02 -> digit 0 dark in frames 4..7 of every 8; digit 7 never lit; dp_o low only while digit 1 is lit.
- load_i on the boundary cycle -> new data shown in the immediately following frame; rst_i mid-frame -> all outputs ones within the same cycle and pending cleared.
